// File: rtl/qk_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qk_inst_sequencer
// Description : Autonomous instruction sequencer for the Q.K attention core.
//               Runs the phase order K load -> settle -> Q execute -> settle
//               -> ofifo->pmem drain -> pmem readback, emitting one packed
//               instruction word per cycle. While idle it forwards the host
//               instruction so the host can still drive the core directly.
// Ports       : clk, reset (async, active high)
//               start, abort             - sequence control
//               num_q, num_k             - counts, latched and clamped at start
//               skip_load, skip_read     - phase bypass, latched at start
//               host_inst                - forwarded to inst while idle
//               inst                     - {ofifo_rd, qkmem_add, pmem_add,
//                                           execute, load, qmem_rd, qmem_wr,
//                                           kmem_rd, kmem_wr, pmem_rd, pmem_wr}
//               busy, done               - status
// Revision    : 1.0 - initial release
// ============================================================================
module qk_inst_sequencer #(
   parameter int aw  = 4,
   parameter int col = 8,
   parameter int gap = 10,
   parameter int iw  = 2*aw+9
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [aw:0]          num_q,
   input  logic [$clog2(col):0] num_k,
   input  logic                 skip_load,
   input  logic                 skip_read,
   input  logic [iw-1:0]        host_inst,
   output logic [iw-1:0]        inst,
   output logic                 busy,
   output logic                 done
);

   localparam int c_kw      = $clog2(col) + 1;
   localparam int c_qw      = aw + 1;
   // The phase counter must hold the longest phase: LOAD, a GAP or a Q phase.
   localparam int c_len_a   = ((col + 2) > (1 << aw)) ? (col + 2) : (1 << aw);
   localparam int c_len_max = (gap > c_len_a) ? gap : c_len_a;
   localparam int c_cw      = $clog2(c_len_max + 1);

   localparam logic [c_kw-1:0] c_k_max    = c_kw'(col);
   localparam logic [c_qw-1:0] c_q_max    = c_qw'(1 << aw);
   localparam logic [c_cw-1:0] c_gap_len  = c_cw'(gap);
   localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
   localparam logic [aw-1:0]   c_addr_one = aw'(1);
   localparam logic            c_gap_on   = (gap != 0);

   // Instruction field positions
   localparam int c_b_pmem_wr = 0;
   localparam int c_b_pmem_rd = 1;
   localparam int c_b_kmem_rd = 3;
   localparam int c_b_qmem_rd = 5;
   localparam int c_b_load    = 6;
   localparam int c_b_execute = 7;
   localparam int c_b_pmem_a  = 8;
   localparam int c_b_qk_a    = 8 + aw;
   localparam int c_b_ofifo   = 8 + 2*aw;

   // Phase states are numbered in execution order; c_start is the single
   // busy cycle of a sequence whose phases are all skipped.
   localparam logic [3:0] c_idle  = 4'd0;
   localparam logic [3:0] c_load  = 4'd1;
   localparam logic [3:0] c_gap1  = 4'd2;
   localparam logic [3:0] c_exec  = 4'd3;
   localparam logic [3:0] c_gap2  = 4'd4;
   localparam logic [3:0] c_drain = 4'd5;
   localparam logic [3:0] c_tail  = 4'd6;
   localparam logic [3:0] c_read  = 4'd7;
   localparam logic [3:0] c_done  = 4'd8;
   localparam logic [3:0] c_start = 4'd9;

   logic [3:0]      r_state;
   logic [c_cw-1:0] r_cnt;
   logic [iw-1:0]   r_seq;
   logic [c_qw-1:0] r_num_q;
   logic [c_kw-1:0] r_num_k;
   logic            r_skip_load;
   logic            r_skip_read;

   logic            w_start;
   logic [c_qw-1:0] w_num_q_cl;
   logic [c_kw-1:0] w_num_k_cl;
   logic [c_qw-1:0] w_num_q;
   logic [c_kw-1:0] w_num_k;
   logic            w_skip_load;
   logic            w_skip_read;
   logic [7:1]      w_en;
   logic [c_cw-1:0] w_len;
   logic [3:0]      w_nstate;
   logic [c_cw-1:0] w_ncnt;
   logic [iw-1:0]   w_word;

   // First enabled phase strictly after state s; c_done when none remain.
   function automatic logic [3:0] f_next(input logic [3:0] s, input logic [7:1] en);
      logic [3:0] nxt;
      nxt = c_done;
      if (s < c_read  && en[7]) nxt = c_read;
      if (s < c_tail  && en[6]) nxt = c_tail;
      if (s < c_drain && en[5]) nxt = c_drain;
      if (s < c_gap2  && en[4]) nxt = c_gap2;
      if (s < c_exec  && en[3]) nxt = c_exec;
      if (s < c_gap1  && en[2]) nxt = c_gap1;
      if (s < c_load  && en[1]) nxt = c_load;
      return nxt;
   endfunction

   assign w_start    = (r_state == c_idle) && start && !abort;
   assign w_num_k_cl = (num_k > c_k_max) ? c_k_max : num_k;
   assign w_num_q_cl = (num_q > c_q_max) ? c_q_max : num_q;

   // On the start cycle the fresh inputs decide the first phase; afterwards
   // only the latched copies matter.
   assign w_num_k     = w_start ? w_num_k_cl : r_num_k;
   assign w_num_q     = w_start ? w_num_q_cl : r_num_q;
   assign w_skip_load = w_start ? skip_load  : r_skip_load;
   assign w_skip_read = w_start ? skip_read  : r_skip_read;

   assign w_en[1] = !w_skip_load && (w_num_k != '0);
   assign w_en[2] = w_en[1] && c_gap_on;
   assign w_en[3] = (w_num_q != '0);
   assign w_en[4] = w_en[3] && c_gap_on;
   assign w_en[5] = w_en[3];
   assign w_en[6] = w_en[3] && !w_skip_read;
   assign w_en[7] = w_en[6];

   always_comb begin
      w_len = c_cnt_one;
      case (r_state)
         c_load:                   w_len = c_cw'(r_num_k) + c_cw'(2);
         c_gap1, c_gap2:           w_len = c_gap_len;
         c_exec, c_drain, c_read:  w_len = c_cw'(r_num_q);
         default:                  w_len = c_cnt_one;
      endcase
   end

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      case (r_state)
         c_idle: begin
            if (w_start) begin
               w_nstate = f_next(c_idle, w_en);
               if (w_nstate == c_done) w_nstate = c_start;
               w_ncnt = '0;
            end
         end
         c_start: w_nstate = c_done;
         c_done:  w_nstate = c_idle;
         default: begin
            if (r_cnt == w_len - c_cnt_one) begin
               w_nstate = f_next(r_state, w_en);
               w_ncnt   = '0;
            end else begin
               w_ncnt = r_cnt + c_cnt_one;
            end
         end
      endcase
      if (abort) begin
         w_nstate = c_idle;
         w_ncnt   = '0;
      end
   end

   // The word for the upcoming cycle is built from the next state/count so
   // that it is already registered when that cycle begins.
   always_comb begin
      w_word = '0;
      case (w_nstate)
         c_load: begin
            w_word[c_b_load] = 1'b1;
            if ((w_ncnt != '0) && (w_ncnt <= c_cw'(w_num_k))) begin
               w_word[c_b_kmem_rd]       = 1'b1;
               w_word[c_b_qk_a +: aw]    = w_ncnt[aw-1:0] - c_addr_one;
            end
         end
         c_exec: begin
            w_word[c_b_execute]       = 1'b1;
            w_word[c_b_qmem_rd]       = 1'b1;
            w_word[c_b_qk_a +: aw]    = w_ncnt[aw-1:0];
         end
         c_drain: begin
            w_word[c_b_ofifo]         = 1'b1;
            w_word[c_b_pmem_wr]       = 1'b1;
            w_word[c_b_pmem_a +: aw]  = w_ncnt[aw-1:0];
         end
         c_read: begin
            w_word[c_b_pmem_rd]       = 1'b1;
            w_word[c_b_pmem_a +: aw]  = w_ncnt[aw-1:0];
         end
         default: w_word = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_idle;
         r_cnt       <= '0;
         r_seq       <= '0;
         r_num_q     <= '0;
         r_num_k     <= '0;
         r_skip_load <= 1'b0;
         r_skip_read <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_seq   <= w_word;
         if (w_start) begin
            r_num_q     <= w_num_q_cl;
            r_num_k     <= w_num_k_cl;
            r_skip_load <= skip_load;
            r_skip_read <= skip_read;
         end
      end
   end

   assign busy = (r_state != c_idle) && (r_state != c_done);
   assign done = (r_state == c_done);
   assign inst = busy ? r_seq : host_inst;

endmodule
`default_nettype wire

// File: tb/tb_qk_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_qk_inst_sequencer
// Description : Self-checking bench for qk_inst_sequencer. A queue-based
//               model expands each accepted start into the full list of
//               expected instruction words and is compared with the DUT every
//               cycle; literal expectations pin selected words and lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qk_inst_sequencer;

   localparam int aw  = 4;
   localparam int col = 8;
   localparam int gap = 10;
   localparam int iw  = 2*aw+9;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic [aw:0]          num_q = '0;
   logic [$clog2(col):0] num_k = '0;
   logic                 skip_load = 1'b0;
   logic                 skip_read = 1'b0;
   logic [iw-1:0]        host_inst = '0;
   logic [iw-1:0]        inst;
   logic                 busy;
   logic                 done;

   int n_checks = 0;
   int n_pass   = 0;

   qk_inst_sequencer #(.aw(aw), .col(col), .gap(gap), .iw(iw)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .num_q(num_q), .num_k(num_k), .skip_load(skip_load), .skip_read(skip_read),
      .host_inst(host_inst), .inst(inst), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [iw-1:0] mk(input bit ofifo, input int qk, input int pa,
                                        input bit ex, input bit ld, input bit qrd,
                                        input bit krd, input bit prd, input bit pwr);
      logic [aw-1:0] q4;
      logic [aw-1:0] p4;
      q4 = qk[aw-1:0];
      p4 = pa[aw-1:0];
      return {ofifo, q4, p4, ex, ld, qrd, 1'b0, krd, 1'b0, prd, pwr};
   endfunction

   // ---------------- model ----------------
   logic [iw-1:0] exp_q[$];
   bit            m_busy = 1'b0;
   bit            m_done = 1'b0;
   int            cnt_busy = 0;
   int            cnt_done = 0;
   logic [iw-1:0] trace [0:1023];

   task automatic build(input int nq_in, input int nk_in, input bit sl, input bit sr);
      int nq;
      int nk;
      nk = (nk_in > col) ? col : nk_in;
      nq = (nq_in > (1 << aw)) ? (1 << aw) : nq_in;
      exp_q.delete();
      if (!sl && nk > 0) begin
         exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
         for (int c = 1; c <= nk; c++) exp_q.push_back(mk(0, c-1, 0, 0, 1, 0, 1, 0, 0));
         exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
         repeat (gap) exp_q.push_back('0);
      end
      if (nq > 0) begin
         for (int c = 0; c < nq; c++) exp_q.push_back(mk(0, c, 0, 1, 0, 1, 0, 0, 0));
         repeat (gap) exp_q.push_back('0);
         for (int c = 0; c < nq; c++) exp_q.push_back(mk(1, 0, c, 0, 0, 0, 0, 0, 1));
         if (!sr) begin
            exp_q.push_back('0);
            for (int c = 0; c < nq; c++) exp_q.push_back(mk(0, 0, c, 0, 0, 0, 0, 1, 0));
         end
      end
      if (exp_q.size() == 0) exp_q.push_back('0);
   endtask

   always @(posedge clk) begin
      bit was_done;
      was_done = m_done;
      if (reset) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         exp_q.delete();
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            if (abort) begin
               m_busy = 1'b0;
               exp_q.delete();
            end else begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
            end
         end else if (!was_done && start && !abort) begin
            build(int'(num_q), int'(num_k), skip_load, skip_read);
            m_busy = 1'b1;
         end
      end
      #1;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("inst", inst, m_busy ? exp_q[0] : host_inst);
      if (busy) begin
         if (cnt_busy < 1024) trace[cnt_busy] = inst;
         cnt_busy++;
      end
      if (done) cnt_done++;
   end

   // ---------------- stimulus ----------------
   task automatic start_seq(input int nq, input int nk, input bit sl, input bit sr);
      @(negedge clk);
      num_q     = nq[aw:0];
      num_k     = nk[$clog2(col):0];
      skip_load = sl;
      skip_read = sr;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || done) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_terminates"}, (n < 300), 1);
   endtask

   int b;
   int d;
   int n;
   logic seen_ld;
   logic seen_prd;

   initial begin
      host_inst = 17'h1_2345;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_inst", inst, 17'h1_2345);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      // full default sequence, host_inst must be ignored while busy
      host_inst = 17'h1_ABCD;
      b = cnt_busy; d = cnt_done;
      start_seq(8, 8, 0, 0);
      wait_idle("full");
      chk("full_len",  cnt_busy - b, 55);
      chk("full_done", cnt_done - d, 1);
      chk("load_c0",   trace[b],      17'h0_0040);
      chk("load_c1",   trace[b+1],    17'h0_0048);
      chk("load_c8",   trace[b+8],    17'h0_7048);
      chk("load_c9",   trace[b+9],    17'h0_0040);
      chk("exec_c0",   trace[b+20],   17'h0_00A0);
      chk("exec_c7",   trace[b+27],   17'h0_70A0);
      chk("drain_c7",  trace[b+45],   17'h1_0701);
      chk("tail",      trace[b+46],   17'h0_0000);
      chk("read_c7",   trace[b+54],   17'h0_0702);

      // skip load and read
      b = cnt_busy; d = cnt_done;
      start_seq(3, 8, 1, 1);
      wait_idle("skip");
      chk("skip_len",  cnt_busy - b, 16);
      chk("skip_done", cnt_done - d, 1);
      chk("skip_first", trace[b], 17'h0_00A0);
      seen_ld = 1'b0; seen_prd = 1'b0;
      for (int i = 0; i < 16; i++) begin
         seen_ld  = seen_ld  | trace[b+i][6];
         seen_prd = seen_prd | trace[b+i][1];
      end
      chk("skip_no_load",    seen_ld, 0);
      chk("skip_no_pmem_rd", seen_prd, 0);

      // counts beyond limits are clamped
      b = cnt_busy;
      start_seq(31, 15, 0, 0);
      wait_idle("clamp");
      chk("clamp_len",     cnt_busy - b, 79);
      chk("clamp_k_last",  trace[b+8],  17'h0_7048);
      chk("clamp_k_end",   trace[b+9],  17'h0_0040);
      chk("clamp_q_last",  trace[b+35], 17'h0_F0A0);
      chk("clamp_rd_last", trace[b+78], 17'h0_0F02);

      // abort at EXEC c=2
      host_inst = 17'h0_5A5A;
      b = cnt_busy; d = cnt_done;
      start_seq(8, 8, 1, 0);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_inst", inst, 17'h0_5A5A);
      wait_idle("abort");
      chk("abort_len",  cnt_busy - b, 3);
      chk("abort_done", cnt_done - d, 0);

      // full run after abort
      b = cnt_busy; d = cnt_done;
      start_seq(8, 8, 0, 0);
      wait_idle("after_abort");
      chk("after_abort_len",  cnt_busy - b, 55);
      chk("after_abort_done", cnt_done - d, 1);

      // start again and change num_q mid-DRAIN
      b = cnt_busy; d = cnt_done;
      start_seq(8, 8, 0, 0);
      n = 0;
      while ((cnt_busy - b) < 40 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_drain", (n < 100), 1);
      start = 1'b1;
      num_q = 5'd3;
      @(negedge clk);
      start = 1'b0;
      wait_idle("restart");
      chk("restart_len",  cnt_busy - b, 55);
      chk("restart_done", cnt_done - d, 1);

      // abort and start together while idle
      b = cnt_busy;
      @(negedge clk);
      num_q = 5'd8; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start_busy", busy, 0);
      @(negedge clk);
      chk("abort_start_len", cnt_busy - b, 0);

      // every phase skipped
      b = cnt_busy; d = cnt_done;
      start_seq(0, 8, 1, 0);
      wait_idle("empty");
      chk("empty_len",  cnt_busy - b, 1);
      chk("empty_done", cnt_done - d, 1);

      // asynchronous reset mid-sequence
      host_inst = 17'h0_ABCD;
      start_seq(8, 8, 0, 0);
      repeat (5) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_inst", inst, 17'h0_ABCD);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // num_k=0 skips LOAD/GAP1 only
      b = cnt_busy; d = cnt_done;
      start_seq(2, 0, 0, 0);
      wait_idle("k0");
      chk("k0_len",   cnt_busy - b, 17);
      chk("k0_done",  cnt_done - d, 1);
      chk("k0_first", trace[b], 17'h0_00A0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/qk_inst_sequencer.md
# qk_inst_sequencer

Autonomous instruction sequencer for the Q·K attention core. It replaces hand-driven instruction streams with a parametrised state machine that emits the core's packed `inst` word through the fixed phase order: K load, settle, Q execute, settle, ofifo→pmem drain, pmem readback. The block sits between the host/test harness and `core.inst`. When idle it passes host instructions through, so the host can still write Q/K memories directly.

## Interface
Parameters:
- `aw`, 4, Q/K/P memory address width; memory depth is `2**aw`.
- `col`, 8, number of dot-product columns; this is the maximum K rows loaded.
- `gap`, 10, number of all-zero settle cycles after LOAD and after EXEC (0 = no settle cycles).
- `iw`, `2*aw+9`, instruction width (17 with defaults).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a sequence; sampled only in IDLE.
- `abort`  in  1  synchronous abort; the block returns to IDLE on the next edge.
- `num_q`  in  aw+1  number of Q vectors to process; latched at start.
- `num_k`  in  $clog2(col)+1  number of K rows to load; latched at start.
- `skip_load`  in  1  latched at start; when set, LOAD and GAP1 are bypassed (reuse the loaded K).
- `skip_read`  in  1  latched at start; when set, TAIL and READ are bypassed.
- `host_inst`  in  iw  host instruction, forwarded while IDLE.
- `inst`  out  iw  instruction to the core: {ofifo_rd, qkmem_add[aw-1:0], pmem_add[aw-1:0], execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr}.
- `busy`  out  1  high while the sequence is running.
- `done`  out  1  one-cycle pulse when a sequence completes (not asserted on abort).

## Operation
- `inst = busy ? seq_q : host_inst`. `seq_q` is a register; the IDLE path is combinational.
- Latching at start:
  - `num_k` is clamped to `col`.
  - `num_q` is clamped to `2**aw`.
  - A latched count of 0 skips every phase that uses it: `num_k=0` skips LOAD and GAP1; `num_q=0` skips EXEC, GAP2, DRAIN, TAIL and READ.
- States, with `c` being the phase cycle counter starting at 0:
  - IDLE.
  - LOAD, `num_k+2` cycles:
    - `c=0`: `load=1`.
    - `1<=c<=num_k`: `load=1`, `kmem_rd=1`, `qkmem_add=c-1`.
    - `c=num_k+1`: `load=1`, all other fields 0.
  - GAP1, `gap` cycles, all zero.
  - EXEC, `num_q` cycles: `execute=1`, `qmem_rd=1`, `qkmem_add=c`.
  - GAP2, `gap` cycles, all zero.
  - DRAIN, `num_q` cycles: `ofifo_rd=1`, `pmem_wr=1`, `pmem_add=c`.
  - TAIL, 1 cycle, all zero.
  - READ, `num_q` cycles: `pmem_rd=1`, `pmem_add=c`.
  - DONE, 1 cycle: `busy=0`, `done=1`, `inst=host_inst`; the next state is IDLE.
- Phases that are skipped (zero length or via a skip flag) take zero cycles. The next enabled phase follows directly.
- If every phase is skipped, the sequence is START → DONE, and `busy` is high for exactly 1 cycle.
- `qmem_wr` and `kmem_wr` are never asserted by the sequencer.
- Addresses never wrap, because of the clamping above.
- `start` while busy is ignored. `host_inst` is ignored while busy.
- Abort and start in the same IDLE cycle: abort wins, and the sequence does not start.

## Timing
- Reset (asynchronous) puts the block in IDLE with `seq_q=0`, `busy=0`, `done=0`, counters 0 and latched fields 0. `inst` then equals `host_inst`.
- `start` is sampled high at edge N. From edge N, `busy=1` and `seq_q` holds the first enabled phase's `c=0` word.
- One instruction is issued per cycle. There are no bubbles between phases beyond GAP1, GAP2 and TAIL.
- Total busy cycles: (`num_k+2+gap` unless skipped) + `num_q` + `gap` + `num_q` + (`1+num_q` unless `skip_read`).
- `done` rises at the edge after the last busy cycle and lasts exactly 1 cycle.
- `abort` sampled high at any edge while busy: at that edge `busy=0` and `seq_q=0`, with no `done`.
- Reset asserted mid-sequence: outputs take their reset values immediately (asynchronously).

## Test plan
- Reset, then `host_inst=17'h1_2345` while idle → `inst=17'h1_2345`, `busy=0`, `done=0`.
- Defaults, `num_k=8`, `num_q=8`, no skips → `busy` high 55 cycles:
  - LOAD `qkmem_add` runs 0..7 with `kmem_rd`.
  - EXEC `qkmem_add` runs 0..7.
  - DRAIN `pmem_add` runs 0..7 with `ofifo_rd` and `pmem_wr`.
  - READ `pmem_add` runs 0..7.
  - `done` pulses once.
- `skip_load=1`, `skip_read=1`, `num_q=3` → 16 busy cycles: EXEC 3, GAP 10, DRAIN 3. No `load` or `pmem_rd` is seen.
- `num_k=15`, `num_q=31` (beyond limits) → clamped to 8 and 16; maximum address 7 (K) and 15 (Q/P).
- `abort` asserted at EXEC `c=2` → `busy=0` at the next edge, `inst` follows `host_inst`, no `done`. A new `start` then runs a full sequence correctly.
- `start` pulsed again mid-DRAIN, and `num_q` changed mid-run → no effect; the sequence length is unchanged.
